// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX word arbiter: default sizes and FSM state encodings.
package uart_tx_arbiter_pkg;

   localparam int unsigned DEF_NREQ    = 4;
   localparam int unsigned DEF_NB_WORD = 32;
   localparam int unsigned DEF_DBIT    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_NEXT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first request at or above ptr, wrapping.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PW'((32'(ptr) + i) % N);
         for (int unsigned k = 0; k < N; k++) begin
            if (!found && idx == PW'(k) && req[k]) begin
               grant[k] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NREQ word requesters onto a byte-wide UART TX FIFO; packets are never interleaved
// and each word is sent MSB byte first.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NREQ    = DEF_NREQ,
   parameter int unsigned NB_WORD = DEF_NB_WORD,
   parameter int unsigned DBIT    = DEF_DBIT
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [NREQ-1:0]         i_req,
   input  logic [NREQ*NB_WORD-1:0] i_word,
   input  logic [NREQ-1:0]         i_last,
   output logic [NREQ-1:0]         o_ack,
   input  logic                    i_tx_full,
   output logic                    o_wr_uart,
   output logic [DBIT-1:0]         o_tx_data,
   output logic [NREQ-1:0]         o_grant,
   output logic                    o_busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t           state;
   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        owner;
   logic [NB_WORD-1:0]   sreg;
   logic [1:0]           byte_cnt;
   logic                 last_q;

   logic [NREQ-1:0]      pick_grant;
   logic [NREQ-1:0]      owner_oh;
   logic [NREQ-1:0]      ack_c;
   logic [PW-1:0]        pick_idx;
   logic [PW-1:0]        sel_idx;
   logic [PW-1:0]        next_ptr;
   logic [NB_WORD-1:0]   word_sel;
   logic                 last_sel;
   logic                 accept;

   rr_pick #(.N(NREQ), .PW(PW)) u_rr_pick (
      .req   (i_req),
      .ptr   (rr_ptr),
      .grant (pick_grant)
   );

   // One-hot/index conversions and the word/last mux for the requester being accepted
   always_comb begin
      pick_idx = '0;
      owner_oh = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (pick_grant[k]) pick_idx = PW'(k);
         owner_oh[k] = (owner == PW'(k));
      end
      sel_idx  = (state == ST_NEXT) ? owner : pick_idx;
      word_sel = '0;
      last_sel = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (sel_idx == PW'(k)) begin
            word_sel = i_word[k*NB_WORD +: NB_WORD];
            last_sel = i_last[k];
         end
      end
   end

   // IDLE offers the round-robin pick; NEXT offers only the packet owner
   always_comb begin
      ack_c = '0;
      case (state)
         ST_IDLE: ack_c = pick_grant;
         ST_NEXT: ack_c = owner_oh & i_req;
         default: ack_c = '0;
      endcase
   end

   assign accept   = |ack_c;
   assign next_ptr = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         sreg     <= '0;
         byte_cnt <= '0;
         last_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_NEXT: begin
               if (accept) begin
                  sreg     <= word_sel;
                  last_q   <= last_sel;
                  owner    <= sel_idx;
                  byte_cnt <= '0;
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!i_tx_full) begin
                  sreg     <= sreg << DBIT;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     if (last_q) begin
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                     end else begin
                        state  <= ST_NEXT;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Reset forces every output low in the same cycle it is asserted
   assign o_ack     = i_reset ? '0 : ack_c;
   assign o_wr_uart = !i_reset && (state == ST_SEND) && !i_tx_full;
   assign o_tx_data = i_reset ? '0 : sreg[NB_WORD-1 -: DBIT];
   assign o_grant   = (i_reset || state == ST_IDLE) ? '0 : owner_oh;
   assign o_busy    = !i_reset && (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single word, contention, packet lock, backpressure,
// NEXT stall and mid-transfer reset.
module tb_uart_tx_arbiter;

   logic         clk;
   logic         reset;
   logic [3:0]   req;
   logic [127:0] word;
   logic [3:0]   last;
   logic         full;
   logic [3:0]   o_ack;
   logic         o_wr_uart;
   logic [7:0]   o_tx_data;
   logic [3:0]   o_grant;
   logic         o_busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int viol;
   int n;

   logic [7:0] wr_q[$];
   int         ack_q[$];
   int         ack_cyc[$];

   uart_tx_arbiter dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_req     (req),
      .i_word    (word),
      .i_last    (last),
      .o_ack     (o_ack),
      .i_tx_full (full),
      .o_wr_uart (o_wr_uart),
      .o_tx_data (o_tx_data),
      .o_grant   (o_grant),
      .o_busy    (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record FIFO writes and accepted words at the transfer edge
   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         if (o_wr_uart) wr_q.push_back(o_tx_data);
         for (int k = 0; k < 4; k++)
            if (o_ack[k] && req[k]) begin
               ack_q.push_back(k);
               ack_cyc.push_back(cyc);
            end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input int k, input logic [31:0] v);
      word[k*32 +: 32] = v;
   endtask

   task automatic clear_logs();
      wr_q.delete();
      ack_q.delete();
      ack_cyc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      last  = '0;
      full  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      #1;
      while (o_busy && k < 60) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(tag, o_busy, 1'b0);
   endtask

   logic [31:0] exp_w;
   logic [31:0] got_w;
   logic [31:0] pkt[3];

   initial begin
      reset = 1'b1; req = '0; word = '0; last = '0; full = 1'b0;

      // Reset: outputs held low even with every request asserted
      req = 4'hF; last = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ack",   o_ack,     4'h0);
      check("rst_wr",    o_wr_uart, 1'b0);
      check("rst_grant", o_grant,   4'h0);
      check("rst_busy",  o_busy,    1'b0);
      check("rst_data",  o_tx_data, 8'h00);

      // Single word from requester 0
      req = 4'b0001; last = 4'hF; set_word(0, 32'hDEADBEEF);
      reset = 1'b0;
      clear_logs();
      #1 check("single_ack", o_ack, 4'b0001);
      exp_w = 32'hDEADBEEF;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         req = '0;
         #1;
         check("single_wr",    o_wr_uart, 1'b1);
         check("single_byte",  o_tx_data, exp_w[31:24]);
         check("single_grant", o_grant,   4'b0001);
         exp_w = exp_w << 8;
      end
      @(negedge clk);
      #1;
      check("single_idle",  o_busy,  1'b0);
      check("single_gidle", o_grant, 4'h0);
      req = 4'b0011;
      #1 check("single_rrptr1", o_ack, 4'b0010);
      req = '0;

      // Contention: four single-word packets, round-robin order
      do_reset();
      set_word(0, 32'h10111213); set_word(1, 32'h20212223);
      set_word(2, 32'h30313233); set_word(3, 32'h40414243);
      last = 4'hF; req = 4'hF;
      n = 0;
      while (ack_q.size() < 5 && n < 60) begin
         @(negedge clk);
         n++;
      end
      req = '0;
      check("cont_count", (ack_q.size() >= 5), 1'b1);
      if (ack_q.size() >= 5) begin
         check("cont_o0", ack_q[0], 0);
         check("cont_o1", ack_q[1], 1);
         check("cont_o2", ack_q[2], 2);
         check("cont_o3", ack_q[3], 3);
         check("cont_o4", ack_q[4], 0);
         check("cont_word_gap", ack_cyc[1] - ack_cyc[0], 5);
         check("cont_round",    ack_cyc[4] - ack_cyc[0], 20);
      end
      wait_idle("cont_idle");
      check("cont_nbytes", wr_q.size(), 20);
      if (wr_q.size() >= 8) begin
         check("cont_b0", wr_q[0], 8'h10);
         check("cont_b3", wr_q[3], 8'h13);
         check("cont_b4", wr_q[4], 8'h20);
         check("cont_b7", wr_q[7], 8'h23);
      end

      // Packet lock: requester 1 sends 3 words while requester 2 waits
      do_reset();
      pkt[0] = 32'hA1A2A3A4; pkt[1] = 32'hB1B2B3B4; pkt[2] = 32'hC1C2C3C4;
      set_word(2, 32'h55667788); last = 4'b0100; req = 4'b0110;
      viol = 0;
      for (int w = 0; w < 3; w++) begin
         set_word(1, pkt[w]);
         last[1] = (w == 2);
         n = 0;
         #1;
         while (!o_ack[1] && n < 40) begin
            if (o_ack[2]) viol++;
            if (o_busy && o_grant != 4'b0010) viol++;
            @(negedge clk);
            #1;
            n++;
         end
         check("lock_ack1", o_ack[1], 1'b1);
         if (o_ack[2]) viol++;
         @(negedge clk);
         if (w == 2) req[1] = 1'b0;
      end
      n = 0;
      #1;
      while (!o_ack[2] && n < 40) begin
         if (o_busy && o_grant != 4'b0010) viol++;
         @(negedge clk);
         #1;
         n++;
      end
      check("lock_ack2",  o_ack[2], 1'b1);
      check("lock_bytes", wr_q.size(), 12);
      check("lock_viol",  viol, 0);
      check("lock_nacks", ack_q.size(), 3);
      if (wr_q.size() == 12) begin
         check("lock_b0",  wr_q[0],  8'hA1);
         check("lock_b4",  wr_q[4],  8'hB1);
         check("lock_b11", wr_q[11], 8'hC4);
      end
      @(negedge clk);
      req = '0;
      wait_idle("lock_idle");

      // Backpressure during the second byte
      do_reset();
      set_word(0, 32'h11223344); last = 4'b0001; req = 4'b0001;
      #1 check("bp_ack", o_ack, 4'b0001);
      @(negedge clk);
      req = '0;
      #1;
      check("bp_wr0",   o_wr_uart, 1'b1);
      check("bp_data0", o_tx_data, 8'h11);
      @(negedge clk);
      full = 1'b1;
      #1;
      check("bp_nowr",  o_wr_uart, 1'b0);
      check("bp_hold",  o_tx_data, 8'h22);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("bp_nowr",  o_wr_uart, 1'b0);
         check("bp_hold",  o_tx_data, 8'h22);
      end
      @(negedge clk);
      full = 1'b0;
      #1;
      check("bp_resume", o_wr_uart, 1'b1);
      check("bp_data1",  o_tx_data, 8'h22);
      wait_idle("bp_idle");
      check("bp_nbytes", wr_q.size(), 4);
      if (wr_q.size() == 4) begin
         got_w = {wr_q[0], wr_q[1], wr_q[2], wr_q[3]};
         check("bp_seq", got_w, 32'h11223344);
      end

      // NEXT stall: owner pauses between words, requester 1 must wait
      do_reset();
      set_word(0, 32'h01020304); set_word(1, 32'h0A0B0C0D);
      last = 4'b0010; req = 4'b0011;
      #1 check("stall_ack0", o_ack, 4'b0001);
      @(negedge clk);
      req[0] = 1'b0;
      repeat (4) @(negedge clk);
      viol = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (!o_busy || o_ack != 4'h0) viol++;
         @(negedge clk);
      end
      check("stall_viol", viol, 0);
      set_word(0, 32'h05060708); last[0] = 1'b1; req[0] = 1'b1;
      #1 check("stall_resume", o_ack, 4'b0001);
      @(negedge clk);
      req[0] = 1'b0;
      n = 0;
      #1;
      while (!o_ack[1] && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("stall_ack1", o_ack[1], 1'b1);
      @(negedge clk);
      req = '0;
      wait_idle("stall_idle");
      check("stall_nacks", ack_q.size(), 3);
      if (ack_q.size() == 3) check("stall_order", {ack_q[0][1:0], ack_q[1][1:0], ack_q[2][1:0]}, 6'b00_00_01);
      check("stall_nbytes", wr_q.size(), 12);
      if (wr_q.size() == 12) begin
         check("stall_b3", wr_q[3], 8'h04);
         check("stall_b4", wr_q[4], 8'h05);
         check("stall_b8", wr_q[8], 8'h0A);
      end

      // Mid-transfer reset after two bytes of requester 2's word
      do_reset();
      set_word(1, 32'h61626364); last = 4'hF; req = 4'b0010;
      @(negedge clk);
      req = '0;
      wait_idle("mid_pre_idle");
      set_word(2, 32'hAABBCCDD); req = 4'b0100;
      @(negedge clk);
      req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_wr",    o_wr_uart, 1'b0);
      check("mid_rst_busy",  o_busy,    1'b0);
      check("mid_rst_grant", o_grant,   4'h0);
      check("mid_rst_data",  o_tx_data, 8'h00);
      @(negedge clk);
      #1;
      check("mid_post_busy", o_busy,    1'b0);
      check("mid_post_data", o_tx_data, 8'h00);
      check("mid_written", wr_q.size(), 6);
      if (wr_q.size() == 6) begin
         check("mid_b4", wr_q[4], 8'hAA);
         check("mid_b5", wr_q[5], 8'hBB);
      end
      reset = 1'b0;
      #1;
      check("mid_sreg_clear", o_tx_data, 8'h00);
      req = 4'b1000;
      #1 check("mid_req3", o_ack, 4'b1000);
      req = 4'b1010;
      #1 check("mid_ptr0", o_ack, 4'b0010);
      req = '0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
